// File: rtl/systolic_2x2_feeder.sv
// Job controller for a 2x2 systolic array: latches A/B, feeds skewed operands,
// drives enable/clear, and holds the captured C matrix until it is consumed.
module systolic_2x2_feeder #(
  parameter int unsigned data_width   = 8,
  parameter int unsigned acc_width    = 2 * data_width,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4*data_width-1:0]   a_mat,
  input  logic [4*data_width-1:0]   b_mat,
  output logic                      arr_clr,
  output logic                      arr_en,
  output logic [data_width-1:0]     arr_a0,
  output logic [data_width-1:0]     arr_a1,
  output logic [data_width-1:0]     arr_b0,
  output logic [data_width-1:0]     arr_b1,
  input  logic [acc_width-1:0]      arr_c00,
  input  logic [acc_width-1:0]      arr_c01,
  input  logic [acc_width-1:0]      arr_c10,
  input  logic [acc_width-1:0]      arr_c11,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [4*acc_width-1:0]    c_mat,
  output logic                      busy
);

  localparam int unsigned DW     = data_width;
  localparam int unsigned CntMax = (DRAIN_CYCLES > 3) ? DRAIN_CYCLES : 3;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [4*DW-1:0]        a_q, a_d, b_q, b_d;
  logic [4*acc_width-1:0] c_q, c_d;
  logic                   res_valid_q, res_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   arr_clr_q, arr_clr_d;
  logic                   arr_en_q, arr_en_d;
  logic                   busy_q, busy_d;
  logic [DW-1:0]          a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;

  // Next-state, datapath captures and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_valid_d = res_valid_q;
    a0_d        = '0;
    a1_d        = '0;
    b0_d        = '0;
    b1_d        = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_CLEAR;
          a_d     = a_mat;
          b_d     = b_mat;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = CntW'(2);
      end
      S_FEED: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = CntW'(DRAIN_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          c_d         = {arr_c11, arr_c10, arr_c01, arr_c00};
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Feed slot = 2 - cnt; operands are staged one cycle ahead of the array
    if (state_d == S_FEED) begin
      case (cnt_d)
        CntW'(2): begin
          a0_d = a_d[0*DW +: DW];
          b0_d = b_d[0*DW +: DW];
        end
        CntW'(1): begin
          a0_d = a_d[1*DW +: DW];
          a1_d = a_d[2*DW +: DW];
          b0_d = b_d[2*DW +: DW];
          b1_d = b_d[1*DW +: DW];
        end
        CntW'(0): begin
          a1_d = a_d[3*DW +: DW];
          b1_d = b_d[3*DW +: DW];
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d == S_IDLE);
    arr_clr_d  = (state_d == S_CLEAR);
    arr_en_d   = (state_d == S_FEED) || (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      arr_clr_q   <= 1'b0;
      arr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      arr_clr_q   <= arr_clr_d;
      arr_en_q    <= arr_en_d;
      busy_q      <= busy_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign arr_clr   = arr_clr_q;
  assign arr_en    = arr_en_q;
  assign arr_a0    = a0_q;
  assign arr_a1    = a1_q;
  assign arr_b0    = b0_q;
  assign arr_b1    = b1_q;
  assign res_valid = res_valid_q;
  assign c_mat     = c_q;
  assign busy      = busy_q;

endmodule
